bcd_serial_addsub: RTL and testbench
====================================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter: NDIG, default 4, number of BCD digits per operand; data width W = 4*NDIG.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all state changes on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: request a new operation.
- sub, in, 1: 0 = a+b, 1 = a-b.
- a, in, W: BCD operand A; digit 0 in bits [3:0].
- b, in, W: BCD operand B.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.
- result, out, W: BCD magnitude of the result.
- cout, out, 1: decimal carry out of an add, i.e. sum >= 10^NDIG.
- neg, out, 1: subtract result is negative.
- invalid, out, 1: an operand digit was greater than 9.
REQ-003 There shall be one clock (clk); reset (rst) shall be asynchronous and active-high.

Function
REQ-004 FSM states shall be IDLE, ADD, FIX and DONE; busy shall be 1 exactly in ADD and FIX.
REQ-005 start shall be accepted only in IDLE or DONE; start in ADD or FIX shall be ignored, with no effect on any output.
REQ-006 On acceptance, the block shall register a, b and sub, clear cout/neg/invalid, set digit index to 0 and carry to sub, and go to ADD.
- Exception: if any digit of a or b is >9, it shall instead set invalid=1 and result=0 and go to DONE.
REQ-007 ADD shall process digit i per cycle:
- b' = sub ? 9-b_i : b_i.
- s = a_i + b' + carry (5-bit binary).
- If s>9: digit = (s+6) mod 16, carry = 1. Else: digit = s, carry = 0.
- digit is written to result digit i.
REQ-008 After digit NDIG-1 of ADD, the block shall branch as follows:
- add: cout = carry, go to DONE.
- sub with carry=1: neg = 0, go to DONE.
- sub with carry=0: neg = 1, carry = 1, index = 0, go to FIX.
REQ-009 FIX shall replace result digit i with (9 - r_i) + carry, using the same correction as REQ-007, one digit per cycle, then go to DONE, so result holds |a-b|.
REQ-010 DONE shall last one cycle with done=1, then go to IDLE unless start is accepted in that cycle.
REQ-011 done shall rise a fixed number of rising edges after the accepting edge:
- NDIG+1 edges: add, or sub with a nonnegative result.
- 2*NDIG+1 edges: sub with a negative result.
- 1 edge: invalid operands.
REQ-012 result, cout, neg and invalid shall hold their values from done until the next accepted start.
REQ-013 A zero difference (a==b, sub=1) shall give result 0, neg=0.
REQ-014 Back-to-back start in the DONE cycle shall begin the next operation with no idle cycle.

Reset
REQ-015 rst=1 shall immediately force:
- state IDLE, busy=0, done=0;
- result=0, cout=0, neg=0, invalid=0;
- internal index and carry to 0.
REQ-016 rst asserted during ADD or FIX shall abort the operation; no done shall follow.

Structure
REQ-017 A shared package bcd_pkg shall hold:
- the state enumeration;
- BCD_MAX=9 and BCD_CORR=6;
- default NDIG.
REQ-018 One combinational sub-module, bcd_digit_adder, shall perform a 4-bit binary add with carry plus decimal correction; it shall be instantiated once and shared by ADD and FIX.
REQ-019 Operand, result, index and carry registers shall be the only sequential elements besides the state register.

Verification
REQ-020 The bench shall cover these scenarios (NDIG=4):
- Add 0x1234+0x5678: result 0x6912, cout=0, neg=0; done 5 edges after start.
- Add 0x9999+0x0001: result 0x0000, cout=1.
- Sub 0x5000-0x1234: result 0x3766, neg=0; done after 5 edges.
- Sub 0x0123-0x0456: result 0x0333, neg=1; done after 9 edges. Then sub 0x0777-0x0777: result 0x0000, neg=0.
- a=0x00A0, add: invalid=1, result 0, done after 1 edge.
- start pulsed again during ADD: ignored. rst pulsed mid-ADD: all outputs 0, no done. Next op starts cleanly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor: FSM states,
// decimal constants and the default operand size.
package bcd_pkg;

    localparam int NDIG_DEFAULT = 4;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        FIX,
        DONE
    } state_t;

    // Nine's complement of one BCD digit.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder: 4-bit binary add with carry-in, then decimal
// correction so the output is a valid BCD digit plus decimal carry.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (raw > {1'b0, BCD_MAX}) begin
            // The add wraps modulo 16, which drops the decimal carry bit.
            sum  = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract. Subtraction is done as a + 9's complement
// of b + 1; a negative result is turned into its magnitude by a second pass.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result,
    output logic              cout,
    output logic              neg,
    output logic              invalid
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    state_t        state, next_state;
    logic [W-1:0]  a_reg, b_reg, result_reg;
    logic          sub_reg;
    logic [IW-1:0] idx;
    logic          carry;
    logic          cout_reg, neg_reg, invalid_reg;

    logic          accept;
    logic          bad_digit;
    logic          last_digit;
    logic [3:0]    add_x, add_y, add_sum;
    logic          add_cout;

    // Digit validity is checked on the live operands so a bad operand can
    // be rejected in the accepting cycle.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX)
                bad_digit = 1'b1;
        end
    end

    assign accept     = start && (state == IDLE || state == DONE);
    assign last_digit = (idx == LAST_IDX);

    // The single digit adder is shared: ADD feeds a_i and (complemented) b_i,
    // FIX feeds the complement of the stored result digit.
    always_comb begin
        if (state == FIX) begin
            add_x = nines_comp(result_reg[4*idx +: 4]);
            add_y = 4'd0;
        end else begin
            add_x = a_reg[4*idx +: 4];
            add_y = sub_reg ? nines_comp(b_reg[4*idx +: 4]) : b_reg[4*idx +: 4];
        end
    end

    bcd_digit_adder u_digit_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: next_state gets a default before the case so no path through
        // this block leaves it unassigned (which would infer a latch).
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    next_state = bad_digit ? DONE : ADD;
                else
                    next_state = IDLE;
            end
            ADD: begin
                if (last_digit)
                    next_state = (!sub_reg || add_cout) ? DONE : FIX;
            end
            FIX: begin
                if (last_digit)
                    next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sub_reg     <= 1'b0;
            result_reg  <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            cout_reg    <= 1'b0;
            neg_reg     <= 1'b0;
            invalid_reg <= 1'b0;
        end else if (accept) begin
            cout_reg <= 1'b0;
            neg_reg  <= 1'b0;
            idx      <= '0;
            if (bad_digit) begin
                invalid_reg <= 1'b1;
                result_reg  <= '0;
                carry       <= 1'b0;
            end else begin
                invalid_reg <= 1'b0;
                a_reg       <= a;
                b_reg       <= b;
                sub_reg     <= sub;
                carry       <= sub;
            end
        end else if (state == ADD) begin
            result_reg[4*idx +: 4] <= add_sum;
            carry                  <= add_cout;
            idx                    <= idx + IW'(1);
            if (last_digit) begin
                idx <= '0;
                if (!sub_reg) begin
                    cout_reg <= add_cout;
                end else if (!add_cout) begin
                    // No end-around carry: the difference is negative and the
                    // stored digits are its ten's complement.
                    neg_reg <= 1'b1;
                    carry   <= 1'b1;
                end
            end
        end else if (state == FIX) begin
            result_reg[4*idx +: 4] <= add_sum;
            carry                  <= add_cout;
            idx                    <= last_digit ? '0 : idx + IW'(1);
        end
    end

    assign busy    = (state == ADD) || (state == FIX);
    assign done    = (state == DONE);
    assign result  = result_reg;
    assign cout    = cout_reg;
    assign neg     = neg_reg;
    assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (NDIG=4): add/sub results, latency,
// invalid operands, ignored start, mid-operation reset and back-to-back starts.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a, b;
    logic        busy, done, cout, neg, invalid;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_addsub #(.NDIG(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .neg     (neg),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen, with the
    // number of rising edges counted from (and including) the accepting edge.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_sub, output int edges);
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        idle_cycles(2);
        n_checks++;
        if ({busy, done, cout, neg, invalid} !== 5'b0 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b neg=%b invalid=%b result=%h, required all 0",
                     busy, done, cout, neg, invalid, result);
        end
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_add();
        int edges;
        run_op(16'h1234, 16'h5678, 1'b0, edges);
        n_checks++;
        if (result !== 16'h6912 || cout !== 1'b0 || neg !== 1'b0) begin
            n_fail++;
            $display("FAIL add_1234_5678: result=%h cout=%b neg=%b, required 6912 0 0", result, cout, neg);
        end
        n_checks++;
        if (edges !== 5) begin
            n_fail++;
            $display("FAIL add_latency: got %0d edges, required 5", edges);
        end
        idle_cycles(1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h6912) begin
            n_fail++;
            $display("FAIL add_hold: done=%b busy=%b result=%h, required 0 0 6912", done, busy, result);
        end

        run_op(16'h9999, 16'h0001, 1'b0, edges);
        n_checks++;
        if (result !== 16'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_9999_0001: result=%h cout=%b, required 0000 1", result, cout);
        end
        idle_cycles(1);

        run_op(16'h9999, 16'h9999, 1'b0, edges);
        n_checks++;
        if (result !== 16'h9998 || cout !== 1'b1 || edges !== 5) begin
            n_fail++;
            $display("FAIL add_9999_9999: result=%h cout=%b edges=%0d, required 9998 1 5", result, cout, edges);
        end
        idle_cycles(1);
    endtask

    task automatic test_sub();
        int edges;
        run_op(16'h5000, 16'h1234, 1'b1, edges);
        n_checks++;
        if (result !== 16'h3766 || neg !== 1'b0 || cout !== 1'b0 || edges !== 5) begin
            n_fail++;
            $display("FAIL sub_5000_1234: result=%h neg=%b cout=%b edges=%0d, required 3766 0 0 5",
                     result, neg, cout, edges);
        end
        idle_cycles(1);

        run_op(16'h0123, 16'h0456, 1'b1, edges);
        n_checks++;
        if (result !== 16'h0333 || neg !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_0123_0456: result=%h neg=%b, required 0333 1", result, neg);
        end
        n_checks++;
        if (edges !== 9) begin
            n_fail++;
            $display("FAIL sub_neg_latency: got %0d edges, required 9", edges);
        end
        idle_cycles(1);

        run_op(16'h0777, 16'h0777, 1'b1, edges);
        n_checks++;
        if (result !== 16'h0000 || neg !== 1'b0 || edges !== 5) begin
            n_fail++;
            $display("FAIL sub_zero: result=%h neg=%b edges=%0d, required 0000 0 5", result, neg, edges);
        end
        idle_cycles(1);
    endtask

    task automatic test_invalid();
        int edges;
        run_op(16'h00A0, 16'h0001, 1'b0, edges);
        n_checks++;
        if (invalid !== 1'b1 || result !== 16'h0000 || edges !== 1) begin
            n_fail++;
            $display("FAIL invalid_operand: invalid=%b result=%h edges=%0d, required 1 0000 1",
                     invalid, result, edges);
        end
        idle_cycles(1);
        run_op(16'h0011, 16'h0022, 1'b0, edges);
        n_checks++;
        if (invalid !== 1'b0 || result !== 16'h0033) begin
            n_fail++;
            $display("FAIL invalid_clears: invalid=%b result=%h, required 0 0033", invalid, result);
        end
        idle_cycles(1);
    endtask

    task automatic test_ignore_start();
        int edges;
        a     = 16'h1234;
        b     = 16'h5678;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        a     = 16'h9999;
        b     = 16'h9999;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        edges++;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_checks++;
        if (result !== 16'h6912 || neg !== 1'b0 || cout !== 1'b0 || edges !== 5) begin
            n_fail++;
            $display("FAIL ignore_start_result: result=%h neg=%b cout=%b edges=%0d, required 6912 0 0 5",
                     result, neg, cout, edges);
        end
        idle_cycles(1);
    endtask

    task automatic test_abort_reset();
        int  edges;
        logic saw_done;
        a     = 16'h0123;
        b     = 16'h0456;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cout, neg, invalid} !== 5'b0 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b cout=%b neg=%b invalid=%b result=%h, required all 0",
                     busy, done, cout, neg, invalid, result);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: activity seen after abort=%b, required 0", saw_done);
        end
        run_op(16'h0042, 16'h0058, 1'b0, edges);
        n_checks++;
        if (result !== 16'h0100 || cout !== 1'b0 || neg !== 1'b0 || edges !== 5) begin
            n_fail++;
            $display("FAIL abort_restart: result=%h cout=%b neg=%b edges=%0d, required 0100 0 0 5",
                     result, cout, neg, edges);
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        int edges;
        run_op(16'h0250, 16'h0250, 1'b0, edges);
        n_checks++;
        if (result !== 16'h0500 || edges !== 5) begin
            n_fail++;
            $display("FAIL b2b_first: result=%h edges=%0d, required 0500 5", result, edges);
        end
        // Issued in the DONE cycle: must be accepted on the very next edge.
        run_op(16'h0100, 16'h0999, 1'b1, edges);
        n_checks++;
        if (result !== 16'h0899 || neg !== 1'b1 || edges !== 9) begin
            n_fail++;
            $display("FAIL b2b_second: result=%h neg=%b edges=%0d, required 0899 1 9", result, neg, edges);
        end
        run_op(16'h4321, 16'h1111, 1'b1, edges);
        n_checks++;
        if (result !== 16'h3210 || neg !== 1'b0 || edges !== 5) begin
            n_fail++;
            $display("FAIL b2b_third: result=%h neg=%b edges=%0d, required 3210 0 5", result, neg, edges);
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_ignore_start();
        test_abort_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
